// File: rtl/chess_move_ctrl.sv
// chess_move_ctrl: owns the live board and side-to-move for the renderer.
// Sequences a pick/place move from debounced button pulses and defers the
// board write to frame_end, so the 256-bit board never changes mid-frame.
module chess_move_ctrl #(
  parameter logic [5:0] CURSOR_RESET = 6'd12,
  parameter logic [2:0] PROMOTE_TO   = 3'd5
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_new_game,
  input  logic         i_btn_up,
  input  logic         i_btn_down,
  input  logic         i_btn_left,
  input  logic         i_btn_right,
  input  logic         i_btn_sel,
  input  logic         i_frame_end,
  output logic [255:0] o_board_data,
  output logic         o_turn,
  output logic [5:0]   o_cursor_pos,
  output logic [5:0]   o_sel_pos,
  output logic         o_sel_valid,
  output logic         o_move_pending,
  output logic         o_move_done
);

  // Rank 7 (black back rank) is the top word, rank 0 (white back rank) the bottom.
  localparam logic [255:0] INIT_BOARD =
    256'hCABEDBAC_99999999_00000000_00000000_00000000_00000000_11111111_42365324;

  typedef enum logic [1:0] {S_PICK, S_PLACE, S_PEND, S_COMMIT} state_t;

  state_t         r_state;
  logic [255:0]   r_board;
  logic           r_turn;
  logic [5:0]     r_cursor;
  logic [5:0]     r_sel_pos;
  logic [5:0]     r_dst;
  logic           r_sel_valid;
  logic           r_move_pending;
  logic           r_move_done;

  logic [3:0]     w_cur_nib;
  logic [3:0]     w_src_nib;
  logic [3:0]     w_moved_nib;
  logic           w_cur_own;
  logic           w_promote;
  logic [5:0]     w_cursor_nxt;
  logic           w_fwd;
  logic           w_inc;

  assign w_cur_nib   = r_board[{r_cursor, 2'b00} +: 4];
  assign w_src_nib   = r_board[{r_sel_pos, 2'b00} +: 4];
  // An empty square is never "own", whatever its colour bit says.
  assign w_cur_own   = (w_cur_nib[2:0] != 3'd0) && (w_cur_nib[3] == r_turn);
  assign w_promote   = (w_src_nib[2:0] == 3'd1) &&
                       (r_turn ? (r_dst[5:3] == 3'd0) : (r_dst[5:3] == 3'd7));
  assign w_moved_nib = w_promote ? {w_src_nib[3], PROMOTE_TO} : w_src_nib;

  // Next cursor: one saturating step, viewed from the side to move; up>down>left>right.
  always_comb begin
    w_cursor_nxt = r_cursor;
    w_fwd        = 1'b0;
    w_inc        = 1'b0;
    if (i_btn_up || i_btn_down) begin
      // rank+1 for white-up or black-down
      w_fwd = i_btn_up ^ r_turn;
      if (w_fwd && r_cursor[5:3] != 3'd7)       w_cursor_nxt = r_cursor + 6'd8;
      else if (!w_fwd && r_cursor[5:3] != 3'd0) w_cursor_nxt = r_cursor - 6'd8;
    end else if (i_btn_left || i_btn_right) begin
      // file+1 for white-right or black-left
      w_inc = ~(i_btn_left ^ r_turn);
      if (w_inc && r_cursor[2:0] != 3'd7)       w_cursor_nxt = r_cursor + 6'd1;
      else if (!w_inc && r_cursor[2:0] != 3'd0) w_cursor_nxt = r_cursor - 6'd1;
    end
  end

  // Move sequencer FSM with board/turn ownership; new_game acts as a sync reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_PICK;
      r_board        <= INIT_BOARD;
      r_turn         <= 1'b0;
      r_cursor       <= CURSOR_RESET;
      r_sel_pos      <= 6'd0;
      r_dst          <= 6'd0;
      r_sel_valid    <= 1'b0;
      r_move_pending <= 1'b0;
      r_move_done    <= 1'b0;
    end else if (i_new_game) begin
      r_state        <= S_PICK;
      r_board        <= INIT_BOARD;
      r_turn         <= 1'b0;
      r_cursor       <= CURSOR_RESET;
      r_sel_pos      <= 6'd0;
      r_dst          <= 6'd0;
      r_sel_valid    <= 1'b0;
      r_move_pending <= 1'b0;
      r_move_done    <= 1'b0;
    end else begin
      r_move_done <= 1'b0;
      case (r_state)
        S_PICK: begin
          if (i_btn_sel) begin
            if (w_cur_own) begin
              r_sel_pos   <= r_cursor;
              r_sel_valid <= 1'b1;
              r_state     <= S_PLACE;
            end
          end else begin
            r_cursor <= w_cursor_nxt;
          end
        end
        S_PLACE: begin
          if (i_btn_sel) begin
            if (r_cursor == r_sel_pos) begin
              r_sel_valid <= 1'b0;
              r_state     <= S_PICK;
            end else if (w_cur_own) begin
              r_sel_pos <= r_cursor;
            end else begin
              r_dst          <= r_cursor;
              r_move_pending <= 1'b1;
              r_state        <= S_PEND;
            end
          end else begin
            r_cursor <= w_cursor_nxt;
          end
        end
        S_PEND: begin
          // frame_end is only sampled once already in PEND, so a strobe
          // coinciding with the entering sel is not taken.
          if (i_frame_end) r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          r_board[{r_dst, 2'b00} +: 4]     <= w_moved_nib;
          r_board[{r_sel_pos, 2'b00} +: 4] <= 4'h0;
          r_turn         <= ~r_turn;
          r_sel_valid    <= 1'b0;
          r_move_pending <= 1'b0;
          r_move_done    <= 1'b1;
          r_state        <= S_PICK;
        end
        default: r_state <= S_PICK;
      endcase
    end
  end

  assign o_board_data   = r_board;
  assign o_turn         = r_turn;
  assign o_cursor_pos   = r_cursor;
  assign o_sel_pos      = r_sel_pos;
  assign o_sel_valid    = r_sel_valid;
  assign o_move_pending = r_move_pending;
  assign o_move_done    = r_move_done;

endmodule

// File: tb/tb_chess_move_ctrl.sv
// Directed bench for chess_move_ctrl: cursor saturation/priority, pick/place
// ownership, deferred commit, promotion, reset mid-move and new_game.
module tb_chess_move_ctrl;

  localparam logic [255:0] INIT =
    256'hCABEDBAC_99999999_00000000_00000000_00000000_00000000_11111111_42365324;
  // {up, down, left, right, sel, frame_end}
  localparam logic [5:0] UP = 6'b100000, DN = 6'b010000, LF = 6'b001000,
                         RT = 6'b000100, SL = 6'b000010, FE = 6'b000001;

  logic         clk = 1'b0, rst_n = 1'b0, new_game = 1'b0;
  logic         up = 1'b0, dn = 1'b0, lf = 1'b0, rt = 1'b0, sel = 1'b0, fe = 1'b0;
  logic [255:0] board;
  logic         turn, sel_valid, move_pending, move_done;
  logic [5:0]   cursor, sel_pos;

  int           n_chk = 0, n_err = 0;
  logic [255:0] exp_b;
  logic         exp_turn;

  chess_move_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_new_game(new_game),
    .i_btn_up(up), .i_btn_down(dn), .i_btn_left(lf), .i_btn_right(rt),
    .i_btn_sel(sel), .i_frame_end(fe),
    .o_board_data(board), .o_turn(turn), .o_cursor_pos(cursor),
    .o_sel_pos(sel_pos), .o_sel_valid(sel_valid),
    .o_move_pending(move_pending), .o_move_done(move_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive buttons for one cycle starting at a negedge, n times back to back.
  task automatic press(input logic [5:0] b, input int n = 1);
    for (int k = 0; k < n; k++) begin
      {up, dn, lf, rt, sel, fe} = b;
      @(negedge clk);
      {up, dn, lf, rt, sel, fe} = 6'b0;
    end
  endtask

  // From PEND: frame_end, then check the deferred commit and one-cycle move_done.
  task automatic commit_chk(input int src, input int dst, input logic [3:0] nib);
    press(FE);
    chk("pre_commit_board", board, exp_b);
    chk("pre_commit_done", move_done, 1'b0);
    @(negedge clk);
    exp_b[dst*4 +: 4] = nib;
    exp_b[src*4 +: 4] = 4'h0;
    exp_turn = ~exp_turn;
    chk("commit_board", board, exp_b);
    chk("commit_turn", turn, exp_turn);
    chk("commit_done", move_done, 1'b1);
    chk("commit_pending", move_pending, 1'b0);
    chk("commit_sel_valid", sel_valid, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", move_done, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_top_word", board[255:224], 32'hCABEDBAC);
    chk("rst_low_word", board[31:0], 32'h42365324);
    chk("rst_board", board, INIT);
    chk("rst_turn", turn, 1'b0);
    chk("rst_cursor", cursor, 6'd12);
    chk("rst_sel_valid", sel_valid, 1'b0);
    chk("rst_sel_pos", sel_pos, 6'd0);
    chk("rst_pending", move_pending, 1'b0);
    chk("rst_done", move_done, 1'b0);
    exp_b = INIT;
    exp_turn = 1'b0;

    // Cursor movement and saturation (white orientation)
    press(DN);     chk("cur_down", cursor, 6'd4);
    press(LF, 4);  chk("cur_left4", cursor, 6'd0);
    press(LF); press(DN); chk("cur_sat_corner", cursor, 6'd0);
    press(RT, 4);  chk("cur_right4", cursor, 6'd4);
    press(UP, 8);  chk("cur_sat_top", cursor, 6'd60);
    press(DN | LF); chk("prio_down_left", cursor, 6'd52);
    press(LF | RT); chk("prio_left_right", cursor, 6'd51);
    press(RT); press(DN, 5); chk("cur_back_12", cursor, 6'd12);

    // White move 12 -> 28 with deferred commit
    press(SL | UP);
    chk("pick_sel_valid", sel_valid, 1'b1);
    chk("pick_sel_pos", sel_pos, 6'd12);
    chk("sel_ignores_dir", cursor, 6'd12);
    press(UP, 2);  chk("place_cursor", cursor, 6'd28);
    press(SL | FE);
    chk("pend_pending", move_pending, 1'b1);
    chk("pend_board_held", board, INIT);
    press(UP);     chk("pend_cursor_frozen", cursor, 6'd28);
    repeat (2) @(negedge clk);
    chk("pend_entry_fe_ignored", move_pending, 1'b1);
    chk("pend_board_still", board, INIT);
    commit_chk(12, 28, 4'h1);

    // Black: mirrored cursor, ownership, reselect and cancel
    press(UP);     chk("blk_up", cursor, 6'd20);
    press(LF);     chk("blk_left", cursor, 6'd21);
    press(SL);     chk("sel_empty_ignored", sel_valid, 1'b0);
    press(DN, 4); press(RT); chk("blk_nav", cursor, 6'd52);
    press(SL);
    chk("blk_pick", sel_valid, 1'b1);
    chk("blk_pick_pos", sel_pos, 6'd52);
    press(DN); press(SL);
    chk("reselect_valid", sel_valid, 1'b1);
    chk("reselect_pos", sel_pos, 6'd60);
    press(SL);     chk("cancel", sel_valid, 1'b0);
    press(UP); press(SL); press(UP); press(SL);
    chk("blk_pending", move_pending, 1'b1);
    commit_chk(52, 44, 4'h9);

    // White may not pick a black piece
    press(SL);     chk("sel_opponent_ignored", sel_valid, 1'b0);
    press(DN, 2); press(SL);
    chk("w_pick_28", sel_valid, 1'b1);
    press(UP, 3); press(SL);
    commit_chk(28, 52, 4'h1);

    // Black king 60 -> 36 clears the promotion square
    press(DN); press(SL); press(UP, 3); press(SL);
    commit_chk(60, 36, 4'hE);

    // White pawn 52 -> 60 promotes to queen
    press(UP, 2); press(SL); press(UP);
    chk("promo_cursor", cursor, 6'd60);
    press(SL);
    commit_chk(52, 60, 4'h5);

    // Reset while a black move is pending discards it
    press(UP, 2); press(SL); press(LF); press(SL);
    chk("rst_pend_setup", move_pending, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstpend_board", board, INIT);
    chk("rstpend_turn", turn, 1'b0);
    chk("rstpend_pending", move_pending, 1'b0);
    chk("rstpend_cursor", cursor, 6'd12);
    rst_n = 1'b1;
    @(negedge clk);
    press(FE);
    @(negedge clk);
    chk("rstpend_no_done", move_done, 1'b0);
    chk("rstpend_board_after", board, INIT);

    // new_game beats a simultaneous direction press
    press(UP);     chk("ng_pre_cursor", cursor, 6'd20);
    press(SL);
    {up, dn, lf, rt, sel, fe} = UP;
    new_game = 1'b1;
    @(negedge clk);
    {up, dn, lf, rt, sel, fe} = 6'b0;
    new_game = 1'b0;
    chk("ng_cursor", cursor, 6'd12);
    chk("ng_sel_valid", sel_valid, 1'b0);
    chk("ng_board", board, INIT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
